// File: rtl/response_collector.sv
// Serial response collector: captures {cout,sum}, folds it into a MISR and
// shifts either the captured vector or the MISR signature out LSB first.
module response_collector #(
    parameter int         N    = 16,
    parameter logic [N:0] POLY = 17'h00009
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic [N-1:0] sum,
    input  logic         cout,
    input  logic         sig_read,
    input  logic         misr_clr,
    output logic         pin_out,
    output logic         pin_valid,
    output logic         busy,
    output logic         done,
    output logic         overrun
);

    localparam int CW = (N + 1 > 1) ? $clog2(N + 1) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [N:0]      shreg, shreg_next;
    logic [N:0]      misr, misr_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            overrun_next;
    logic            accept_cap;
    logic            pin_out_next, pin_valid_next, busy_next, done_next;
    logic [N:0]      vec;

    // One Galois MISR step: multiply by x modulo POLY, then absorb the input.
    function automatic logic [N:0] misr_step(input logic [N:0] cur, input logic [N:0] din);
        logic [N:0] shifted;
        shifted = {cur[N-1:0], 1'b0};
        if (cur[N]) begin
            shifted = shifted ^ POLY;
        end else begin
            shifted = shifted;
        end
        return shifted ^ din;
    endfunction

    assign vec = {cout, sum};

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        cnt_next     = cnt;
        accept_cap   = 1'b0;
        misr_next    = misr;
        overrun_next = overrun;

        case (state)
            IDLE: begin
                if (capture) begin
                    accept_cap = 1'b1;
                    shreg_next = vec;
                    cnt_next   = {CW{1'b0}};
                    state_next = SHIFT;
                end else if (sig_read) begin
                    shreg_next = misr;
                    cnt_next   = {CW{1'b0}};
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                shreg_next = {1'b0, shreg[N:1]};
                cnt_next   = cnt + CW'(1);
                if (cnt == LAST_BIT) begin
                    state_next = DONE;
                end else begin
                    state_next = SHIFT;
                end
            end
            DONE: begin
                shreg_next = {(N+1){1'b0}};
                cnt_next   = {CW{1'b0}};
                state_next = IDLE;
            end
            default: begin
                shreg_next = {(N+1){1'b0}};
                cnt_next   = {CW{1'b0}};
                state_next = IDLE;
            end
        endcase

        // A clear coinciding with an accepted capture folds the vector into zero.
        if (misr_clr) begin
            if (accept_cap) begin
                misr_next = vec;
            end else begin
                misr_next = {(N+1){1'b0}};
            end
        end else if (accept_cap) begin
            misr_next = misr_step(misr, vec);
        end else begin
            misr_next = misr;
        end

        if (misr_clr) begin
            overrun_next = 1'b0;
        end else if ((state != IDLE) && (capture || sig_read)) begin
            overrun_next = 1'b1;
        end else begin
            overrun_next = overrun;
        end

        pin_valid_next = (state_next == SHIFT);
        busy_next      = (state_next != IDLE);
        done_next      = (state_next == DONE);
        if (state_next == SHIFT) begin
            pin_out_next = shreg_next[0];
        end else begin
            pin_out_next = 1'b0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= {(N+1){1'b0}};
            misr      <= {(N+1){1'b0}};
            cnt       <= {CW{1'b0}};
            overrun   <= 1'b0;
            pin_out   <= 1'b0;
            pin_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            misr      <= misr_next;
            cnt       <= cnt_next;
            overrun   <= overrun_next;
            pin_out   <= pin_out_next;
            pin_valid <= pin_valid_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

endmodule

// File: doc/response_collector.md
Name: response_collector

Overview:
- Far-end counterpart to the adder-input broadcaster in the DFT adder example. The broadcaster fans two tester pins out to the adder's N-bit a/b buses and cin; this block brings the adder's N-bit sum and cout back to a single tester pin.
- On each capture it latches {cout, sum}, folds the vector into a multiple-input signature register (MISR), and shifts the captured vector out serially, LSB first, on pin_out with a valid strobe.
- On request it shifts the accumulated MISR signature out on the same pin.

Parameters:
- N, 16, adder data width; captured vector and MISR are N+1 bits.
- POLY, 17'h00009, Galois feedback polynomial for the MISR, N+1 bits wide (x^17+x^3+1 default).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- capture  input  1  1-cycle request to capture {cout,sum}.
- sum  input  N  adder sum output.
- cout  input  1  adder carry-out.
- sig_read  input  1  1-cycle request to shift out the MISR signature.
- misr_clr  input  1  synchronous clear of MISR and overrun.
- pin_out  output  1  serial data, LSB first.
- pin_valid  output  1  high while pin_out carries a bit.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  1-cycle pulse after the last bit.
- overrun  output  1  sticky: a request was dropped while busy.

Behaviour:
- Reset (async, any state, including mid-shift): transmission aborts; state=IDLE, shift register=0, bit counter=0, MISR=0. All outputs 0: pin_out, pin_valid, busy, done, overrun.
- FSM states: IDLE, SHIFT, DONE.
- IDLE + capture at edge k:
  - shreg <= {cout,sum}.
  - misr <= ({misr[N-1:0],1'b0} ^ (misr[N] ? POLY : 0)) ^ {cout,sum}.
  - cnt <= 0; state -> SHIFT.
- IDLE + sig_read (capture low): shreg <= misr; MISR unchanged; state -> SHIFT.
- IDLE + capture and sig_read in the same cycle: capture wins; sig_read is dropped silently (not an overrun).
- SHIFT timing:
  - pin_out = shreg[0], pin_valid = 1.
  - Each edge: shreg shifts right (zero fill), cnt increments.
  - After N+1 cycles (cnt == N at the edge) -> DONE.
  - First bit is visible in the cycle following edge k, so latency from capture to first bit is 1 cycle.
- DONE: done=1, pin_valid=0, pin_out=0, busy=1 for exactly one cycle, then -> IDLE. A new request is accepted the following cycle at the earliest.
- capture or sig_read while in SHIFT or DONE:
  - Request is ignored: no capture, no MISR update.
  - overrun <= 1 and stays set until misr_clr or rst.
- misr_clr:
  - Acts in any state and clears overrun.
  - Does not affect a shift in progress.
  - With an accepted capture in the same cycle: misr <= {cout,sum} (fold into zero).
  - With an accepted sig_read in the same cycle: shreg loads the pre-clear MISR value.
- pin_out is a direct function of registers; no combinational path from inputs to outputs.
- MISR width is exactly N+1; the shift-out MSB is discarded; no other truncation.

Test Plan:
- Reset, then capture with sum=16'hA5A5, cout=1:
  - Required: pin_valid high for 17 cycles starting 1 cycle after capture.
  - pin_out bits (LSB first) = 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1,1.
  - done pulses in cycle 18; busy is high for 18 cycles.
- Follow with capture sum=16'h0001, cout=0, then sig_read once idle:
  - Required: serial signature = 17'h14B42, LSB first.
  - overrun stays 0.
- capture asserted again at cycle 5 of an active shift:
  - Required: serial stream unchanged, MISR unchanged, overrun=1.
  - overrun cleared by a misr_clr pulse.
- capture and sig_read together in IDLE with sum=16'h0003, cout=0:
  - Required: stream = captured vector 17'h00003, not the signature.
  - overrun stays 0.
- Assert rst asynchronously (mid-cycle) at bit 8 of a shift:
  - Required: all outputs 0 immediately, no done pulse.
  - The next capture restarts cleanly from bit 0 with MISR=0.
- misr_clr and capture same cycle with MISR nonzero, sum=16'h1234, cout=0:
  - Required: a following sig_read emits 17'h01234.
